// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------
// uart_pkg -- shared UART baud encoding, divisor and FSM types | rev 1.0
//------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      BAUD_9600   = 3'd0,
      BAUD_19200  = 3'd1,
      BAUD_38400  = 3'd2,
      BAUD_57600  = 3'd3,
      BAUD_115200 = 3'd4
   } baud_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   localparam int unsigned c_oversample  = 16;
   localparam logic [3:0]  c_samp_tick   = 4'd7;
   localparam logic [3:0]  c_decide_tick = 4'd9;
   localparam logic [3:0]  c_last_tick   = 4'd15;

   // Unused select codes fall back to the slowest rate.
   function automatic int unsigned baud_rate(input logic [2:0] sel);
      int unsigned rate;
      case (sel)
         BAUD_19200:  rate = 19200;
         BAUD_38400:  rate = 38400;
         BAUD_57600:  rate = 57600;
         BAUD_115200: rate = 115200;
         default:     rate = 9600;
      endcase
      return rate;
   endfunction

   function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                input logic [2:0]  sel);
      int unsigned div;
      div = clk_hz / (baud_rate(sel) * c_oversample);
      if (div == 0) div = 1;
      return div;
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_rx_if.sv
//------------------------------------------------------------------------
// uart_byte_rx_if -- serial input and received-byte bus | rev 1.0
//------------------------------------------------------------------------
`default_nettype none

interface uart_byte_rx_if;
   logic       rx;
   logic [2:0] set_baud;
   logic [7:0] data_byte;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   modport slave (
      input  rx,
      input  set_baud,
      output data_byte,
      output rx_done,
      output frame_err,
      output rx_busy
   );

   modport master (
      output rx,
      output set_baud,
      input  data_byte,
      input  rx_done,
      input  frame_err,
      input  rx_busy
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx_baud_gen.sv
//------------------------------------------------------------------------
// uart_rx_baud_gen -- 16x oversampling tick generator | rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module uart_rx_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       clear,
   input  wire logic [2:0] baud_sel,
   output logic            tick
);

   localparam int unsigned c_div_9600   = baud_divisor(CLK_HZ, BAUD_9600);
   localparam int unsigned c_div_19200  = baud_divisor(CLK_HZ, BAUD_19200);
   localparam int unsigned c_div_38400  = baud_divisor(CLK_HZ, BAUD_38400);
   localparam int unsigned c_div_57600  = baud_divisor(CLK_HZ, BAUD_57600);
   localparam int unsigned c_div_115200 = baud_divisor(CLK_HZ, BAUD_115200);
   localparam int          c_cnt_w      = (c_div_9600 > 1) ? $clog2(c_div_9600) : 1;

   localparam logic [c_cnt_w-1:0] c_rl_9600   = c_cnt_w'(c_div_9600   - 1);
   localparam logic [c_cnt_w-1:0] c_rl_19200  = c_cnt_w'(c_div_19200  - 1);
   localparam logic [c_cnt_w-1:0] c_rl_38400  = c_cnt_w'(c_div_38400  - 1);
   localparam logic [c_cnt_w-1:0] c_rl_57600  = c_cnt_w'(c_div_57600  - 1);
   localparam logic [c_cnt_w-1:0] c_rl_115200 = c_cnt_w'(c_div_115200 - 1);

   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic [c_cnt_w-1:0] reload;

   always_comb begin
      case (baud_sel)
         BAUD_19200:  reload = c_rl_19200;
         BAUD_38400:  reload = c_rl_38400;
         BAUD_57600:  reload = c_rl_57600;
         BAUD_115200: reload = c_rl_115200;
         default:     reload = c_rl_9600;
      endcase
   end

   // Down-counter: a tick fires on the zero state, so the period is reload+1.
   always_comb begin
      tick  = (cnt_q == '0);
      cnt_d = cnt_q - 1'b1;
      if (clear || tick) begin
         cnt_d = reload;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_byte_rx.sv
//------------------------------------------------------------------------
// uart_byte_rx -- 16x oversampled 8N1 UART byte receiver | rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   uart_byte_rx_if.slave bus
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       rx_prev_q, rx_prev_d;
   logic [1:0] settle_q, settle_d;
   rx_state_e  state_q, state_d;
   logic [2:0] baud_q, baud_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [1:0] samp_q, samp_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_byte_q, data_byte_d;
   logic       rx_done_q, rx_done_d;
   logic       frame_err_q, frame_err_d;

   logic rx_s;
   logic tick;
   logic start_edge;
   logic bit_maj;
   logic at_decide;
   logic at_end;

   assign rx_s      = sync2_q;
   assign bit_maj   = majority3(samp_q[0], samp_q[1], rx_s);
   assign at_decide = (tick_cnt_q == c_decide_tick);
   assign at_end    = (tick_cnt_q == c_last_tick);

   uart_rx_baud_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_baud_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start_edge),
      .baud_sel (baud_d),
      .tick     (tick)
   );

   always_comb begin
      sync1_d     = bus.rx;
      sync2_d     = sync1_q;
      rx_prev_d   = sync2_q;
      // Edge detection is held off until the reset-forced synchronizer ones
      // have flushed, so a line already low at reset release is not a start.
      settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      state_d     = state_q;
      baud_d      = baud_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      samp_d      = samp_q;
      shift_d     = shift_q;
      data_byte_d = data_byte_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      start_edge  = 1'b0;

      if ((state_q != ST_IDLE) && tick) begin
         tick_cnt_d = tick_cnt_q + 4'd1;
         if (tick_cnt_q == c_samp_tick)        samp_d[0] = rx_s;
         if (tick_cnt_q == c_samp_tick + 4'd1) samp_d[1] = rx_s;
      end

      case (state_q)
         ST_IDLE: begin
            if ((settle_q == 2'd3) && rx_prev_q && !rx_s) begin
               start_edge = 1'b1;
               state_d    = ST_START;
               baud_d     = bus.set_baud;
               tick_cnt_d = 4'd0;
               bit_cnt_d  = 3'd0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (at_decide && bit_maj) begin
                  state_d = ST_IDLE;
               end else if (at_end) begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (at_decide) begin
                  shift_d = {bit_maj, shift_q[7:1]};
               end
               if (at_end) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_STOP;
                  end
               end
            end
         end
         ST_STOP: begin
            // Decide mid-stop-bit and leave at once so a following start
            // edge is not missed.
            if (tick && at_decide) begin
               state_d = ST_IDLE;
               if (bit_maj) begin
                  data_byte_d = shift_q;
                  rx_done_d   = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         settle_q    <= 2'd0;
         state_q     <= ST_IDLE;
         baud_q      <= 3'd0;
         tick_cnt_q  <= 4'd0;
         bit_cnt_q   <= 3'd0;
         samp_q      <= 2'b00;
         shift_q     <= 8'h00;
         data_byte_q <= 8'h00;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         rx_prev_q   <= rx_prev_d;
         settle_q    <= settle_d;
         state_q     <= state_d;
         baud_q      <= baud_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         samp_q      <= samp_d;
         shift_q     <= shift_d;
         data_byte_q <= data_byte_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.data_byte = data_byte_q;
   assign bus.rx_done   = rx_done_q;
   assign bus.frame_err = frame_err_q;
   assign bus.rx_busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx  input  1  serial line; asynchronous to clk; idle high.
REQ-005 SHALL have port set_baud  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
REQ-006 SHALL have port data_byte  output  8  last correctly framed byte received.
REQ-007 SHALL have port rx_done  output  1  one-clk pulse: data_byte updated.
REQ-008 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-009 SHALL have port rx_busy  output  1  high from start-edge detection until return to IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized signal.
REQ-011 SHALL use 16x oversampling; tick divisor = CLK_HZ/(baud*16), integer-truncated (325, 162, 81, 54, 27 at 50 MHz); tick counter reloads at divisor-1.
REQ-012 SHALL latch set_baud at start-edge detection; set_baud changes mid-frame SHALL NOT affect the current frame.
REQ-013 Frame format SHALL be 1 start (0), 8 data LSB first, 1 stop (1); no parity.
REQ-014 Each bit SHALL be decided by 2-of-3 majority of samples at ticks 7, 8, 9 of its 16-tick bit period (tick 0 = first tick after the start edge).
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: high-to-low transition on synchronized rx -> START; tick and bit counters cleared, rx_busy set.
REQ-017 START: majority 1 -> false start; return to IDLE, no rx_done or frame_err pulse; majority 0 -> DATA at end of the start-bit period.
REQ-018 DATA: shift 8 majority-decided bits into a shift register LSB first; after bit 7 period -> STOP.
REQ-019 STOP: majority 1 -> data_byte loaded from shift register and rx_done pulsed in the same clock; majority 0 -> frame_err pulsed, data_byte unchanged.
REQ-020 STOP SHALL return to IDLE on the clock after the stop-bit decision (mid-stop-bit), allowing a following start edge to be detected without waiting for the full stop bit.
REQ-021 rx_done and frame_err SHALL never be high simultaneously and SHALL each be exactly one clk wide.
REQ-022 rx_done latency SHALL be 9 bit periods + 10 ticks after the start edge reaches the synchronizer output, +/-1 tick; synchronizer adds 2 clk.
REQ-023 A line held low continuously SHALL produce exactly one frame_err per 10-bit period of low line... only when a new falling edge occurs; no repeated frames without a high-to-low edge.
REQ-024 data_byte SHALL hold its value between frames.

Reset
REQ-025 On rst_n low: state IDLE, data_byte=8'h00, rx_done=0, frame_err=0, rx_busy=0, counters 0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_done or frame_err pulse; after release, reception SHALL resume only on a fresh falling edge.

Structure
REQ-027 Shared package uart_pkg SHALL hold baud-select encoding, divisor function of CLK_HZ and baud, and FSM state encoding, for use by uart_byte_tx and uart_byte_rx.
REQ-028 One sub-module uart_rx_baud_gen SHALL generate the 16x tick from the latched baud select, cleared at start-edge detection.

Verification
REQ-029 Loopback from uart_byte_tx, set_baud=0, byte 8'h0F -> one rx_done, data_byte=8'h0F, frame_err=0, rx_busy low afterwards.
REQ-030 Back-to-back frames 8'hAA then 8'hEE at set_baud=1 and 2, stop bit 1.0 bit long -> two rx_done pulses, values 8'hAA, 8'hEE in order.
REQ-031 Glitch: rx low for 4 ticks then high, set_baud=4 -> no rx_done, no frame_err, FSM back in IDLE.
REQ-032 Frame 8'h55 with stop bit forced 0 at set_baud=3 -> one frame_err pulse, no rx_done, data_byte keeps prior value.
REQ-033 set_baud changed 0->4 during bit 3 of frame 8'hC3 -> received correctly as 8'hC3 at 9600.
REQ-034 rst_n pulsed low during bit 5 of frame 8'h81 -> all outputs 0, no pulse; next clean frame 8'h7E received correctly.
